// File: rtl/vga_sync_gen.sv
// vga_sync_gen : VGA timing generator.
// Free-running pixel/line counters with zero-latency decode of hsync, vsync
// and activevideo. Optional macro VGA_FRAME_PULSE_EN adds the frame_start
// output, a one-clock pulse at pixel (0,0) of every frame.
// H_TOTAL and V_TOTAL must not exceed 1024 (10-bit counters).
module vga_sync_gen #(
  parameter int H_VISIBLE   = 640,
  parameter int H_FRONT     = 24,
  parameter int H_SYNC      = 40,
  parameter int H_BACK      = 128,
  parameter int V_VISIBLE   = 480,
  parameter int V_FRONT     = 9,
  parameter int V_SYNC      = 3,
  parameter int V_BACK      = 28,
  parameter bit SYNC_ACTIVE = 1'b0
) (
  input  logic       px_clk,
  input  logic       reset,
  output logic       hsync,
  output logic       vsync,
  output logic [9:0] x_px,
  output logic [9:0] y_px,
  output logic       activevideo
`ifdef VGA_FRAME_PULSE_EN
  ,
  output logic       frame_start
`endif
);

  localparam int H_TOTAL = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
  localparam int V_TOTAL = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;

  // Last legal counter values; counters wrap here.
  localparam logic [9:0] H_LAST = 10'(H_TOTAL - 1);
  localparam logic [9:0] V_LAST = 10'(V_TOTAL - 1);

  // Decode bounds are 11 bits wide so an end bound of 1024 stays exact.
  localparam logic [10:0] H_VIS_END  = 11'(H_VISIBLE);
  localparam logic [10:0] H_SYNC_BEG = 11'(H_VISIBLE + H_FRONT);
  localparam logic [10:0] H_SYNC_END = 11'(H_VISIBLE + H_FRONT + H_SYNC);
  localparam logic [10:0] V_VIS_END  = 11'(V_VISIBLE);
  localparam logic [10:0] V_SYNC_BEG = 11'(V_VISIBLE + V_FRONT);
  localparam logic [10:0] V_SYNC_END = 11'(V_VISIBLE + V_FRONT + V_SYNC);

  logic [10:0] x_ext;
  logic [10:0] y_ext;

  assign x_ext = {1'b0, x_px};
  assign y_ext = {1'b0, y_px};

  // Pixel and line counters; reset wins over counting, and the >= test
  // pulls any out-of-range value straight back to a wrap.
  always_ff @(posedge px_clk) begin
    if (reset) begin
      x_px <= 10'd0;
      y_px <= 10'd0;
    end else if (x_px >= H_LAST) begin
      x_px <= 10'd0;
      if (y_px >= V_LAST) begin
        y_px <= 10'd0;
      end else begin
        y_px <= y_px + 10'd1;
      end
    end else begin
      x_px <= x_px + 10'd1;
    end
  end

  // Sync and visible-area decode straight from the counter registers.
  always_comb begin
    hsync       = ~SYNC_ACTIVE;
    vsync       = ~SYNC_ACTIVE;
    activevideo = 1'b0;

    if ((x_ext >= H_SYNC_BEG) && (x_ext < H_SYNC_END)) begin
      hsync = SYNC_ACTIVE;
    end else begin
      hsync = ~SYNC_ACTIVE;
    end

    // Vertical sync looks only at the line number.
    if ((y_ext >= V_SYNC_BEG) && (y_ext < V_SYNC_END)) begin
      vsync = SYNC_ACTIVE;
    end else begin
      vsync = ~SYNC_ACTIVE;
    end

    if ((x_ext < H_VIS_END) && (y_ext < V_VIS_END)) begin
      activevideo = 1'b1;
    end else begin
      activevideo = 1'b0;
    end
  end

`ifdef VGA_FRAME_PULSE_EN
  // One-clock pulse at the first pixel of each frame.
  always_comb begin
    frame_start = 1'b0;
    if ((x_px == 10'd0) && (y_px == 10'd0)) begin
      frame_start = 1'b1;
    end else begin
      frame_start = 1'b0;
    end
  end
`endif

endmodule

// File: tb/tb_vga_sync_gen.sv
// tb_vga_sync_gen : self-checking bench for vga_sync_gen.
// The default-timing instance covers reset and whole-line behaviour; two
// instances with a shrunken raster (28 x 19) cover frame wrap, mid-frame
// reset and inverted sync polarity within a short run.
module tb_vga_sync_gen;

  localparam int DHV = 640, DHF = 24, DHS = 40, DHB = 128;
  localparam int DVV = 480, DVF = 9,  DVS = 3,  DVB = 28;
  localparam int DHT = DHV + DHF + DHS + DHB;
  localparam int DVT = DVV + DVF + DVS + DVB;

  localparam int SHV = 16, SHF = 3, SHS = 4, SHB = 5;
  localparam int SVV = 10, SVF = 2, SVS = 3, SVB = 4;
  localparam int SHT = SHV + SHF + SHS + SHB;
  localparam int SVT = SVV + SVF + SVS + SVB;

  logic px_clk = 1'b0;
  logic rst_d  = 1'b1;
  logic rst_s  = 1'b1;

  logic       hs_d, vs_d, av_d, hs_s, vs_s, av_s, hs_i, vs_i, av_i;
  logic [9:0] x_d, y_d, x_s, y_s, x_i, y_i;
`ifdef VGA_FRAME_PULSE_EN
  logic fs_d, fs_s, fs_i;
`endif

  int tests_run    = 0;
  int tests_failed = 0;

  always #5 px_clk = ~px_clk;

  vga_sync_gen u_dflt (
    .px_clk(px_clk), .reset(rst_d), .hsync(hs_d), .vsync(vs_d),
    .x_px(x_d), .y_px(y_d), .activevideo(av_d)
`ifdef VGA_FRAME_PULSE_EN
    , .frame_start(fs_d)
`endif
  );

  vga_sync_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .SYNC_ACTIVE(1'b0)
  ) u_small (
    .px_clk(px_clk), .reset(rst_s), .hsync(hs_s), .vsync(vs_s),
    .x_px(x_s), .y_px(y_s), .activevideo(av_s)
`ifdef VGA_FRAME_PULSE_EN
    , .frame_start(fs_s)
`endif
  );

  vga_sync_gen #(
    .H_VISIBLE(SHV), .H_FRONT(SHF), .H_SYNC(SHS), .H_BACK(SHB),
    .V_VISIBLE(SVV), .V_FRONT(SVF), .V_SYNC(SVS), .V_BACK(SVB),
    .SYNC_ACTIVE(1'b1)
  ) u_inv (
    .px_clk(px_clk), .reset(rst_s), .hsync(hs_i), .vsync(vs_i),
    .x_px(x_i), .y_px(y_i), .activevideo(av_i)
`ifdef VGA_FRAME_PULSE_EN
    , .frame_start(fs_i)
`endif
  );

  // Reference: n clocks after reset release the raster position is simply
  // n mod H_TOTAL / (n div H_TOTAL) mod V_TOTAL; outputs follow from ranges.
  function automatic logic [22:0] exp_vec(int n, int hv, int hf, int hs, int hb,
                                          int vv, int vf, int vs, int vb, logic act);
    int ht, vt, x, y;
    logic h, v, a;
    ht = hv + hf + hs + hb;
    vt = vv + vf + vs + vb;
    x  = n % ht;
    y  = (n / ht) % vt;
    h  = (x >= hv + hf && x < hv + hf + hs) ? act : ~act;
    v  = (y >= vv + vf && y < vv + vf + vs) ? act : ~act;
    a  = (x < hv) && (y < vv);
    return {10'(x), 10'(y), h, v, a};
  endfunction

  task automatic tick();
    @(posedge px_clk);
    #1;
  endtask

  task automatic test_reset();
    rst_d = 1'b1;
    rst_s = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      tests_run++;
      if ({x_d, y_d, hs_d, vs_d, av_d} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
        tests_failed++;
        $display("FAIL reset_hold cycle %0d: got x=%0d y=%0d hs=%b vs=%b av=%b, want 0 0 1 1 1",
                 i, x_d, y_d, hs_d, vs_d, av_d);
      end
`ifdef VGA_FRAME_PULSE_EN
      tests_run++;
      if (fs_d !== 1'b1) begin
        tests_failed++;
        $display("FAIL reset_frame_start: got %b, want 1", fs_d);
      end
`endif
    end
    rst_d = 1'b0;
    rst_s = 1'b0;
    tests_run++;
    if ({x_d, y_d, hs_d, vs_d, av_d} !== {10'd0, 10'd0, 1'b1, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL reset_release: got x=%0d y=%0d hs=%b vs=%b av=%b, want 0 0 1 1 1",
               x_d, y_d, hs_d, vs_d, av_d);
    end
    tick();
    tests_run++;
    if ({x_d, y_d} !== {10'd1, 10'd0}) begin
      tests_failed++;
      $display("FAIL reset_first_count: got x=%0d y=%0d, want x=1 y=0", x_d, y_d);
    end
  endtask

  task automatic test_line();
    int last;
    int hs_cnt;
    logic [22:0] want;
    rst_d = 1'b1;
    tick();
    rst_d  = 1'b0;
    hs_cnt = 0;
    last   = 3 * DHT + int'($urandom_range(0, 400));
    for (int n = 0; n <= last; n++) begin
      want = exp_vec(n, DHV, DHF, DHS, DHB, DVV, DVF, DVS, DVB, 1'b0);
      tests_run++;
      if ({x_d, y_d, hs_d, vs_d, av_d} !== want) begin
        tests_failed++;
        $display("FAIL line n=%0d: got x=%0d y=%0d hs=%b vs=%b av=%b, want x=%0d y=%0d hs=%b vs=%b av=%b",
                 n, x_d, y_d, hs_d, vs_d, av_d,
                 want[22:13], want[12:3], want[2], want[1], want[0]);
      end
`ifdef VGA_FRAME_PULSE_EN
      tests_run++;
      if (fs_d !== ((n % (DHT * DVT)) == 0)) begin
        tests_failed++;
        $display("FAIL line_frame_start n=%0d: got %b", n, fs_d);
      end
`endif
      if (n < DHT && hs_d == 1'b0) hs_cnt++;
      tick();
    end
    tests_run++;
    if (hs_cnt !== DHS) begin
      tests_failed++;
      $display("FAIL hsync_width: got %0d clocks, want %0d", hs_cnt, DHS);
    end
  endtask

  task automatic test_frame();
    int vs_lo, vs_hi, fs_cnt;
    logic [22:0] want_s, want_i;
    rst_s = 1'b1;
    tick();
    rst_s  = 1'b0;
    vs_lo  = 0;
    vs_hi  = 0;
    fs_cnt = 0;
    for (int n = 0; n < 2 * SHT * SVT + 10; n++) begin
      want_s = exp_vec(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b0);
      want_i = exp_vec(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b1);
      tests_run++;
      if ({x_s, y_s, hs_s, vs_s, av_s} !== want_s) begin
        tests_failed++;
        $display("FAIL frame n=%0d: got x=%0d y=%0d hs=%b vs=%b av=%b, want x=%0d y=%0d hs=%b vs=%b av=%b",
                 n, x_s, y_s, hs_s, vs_s, av_s,
                 want_s[22:13], want_s[12:3], want_s[2], want_s[1], want_s[0]);
      end
      tests_run++;
      if ({x_i, y_i, hs_i, vs_i, av_i} !== want_i) begin
        tests_failed++;
        $display("FAIL frame_inv n=%0d: got x=%0d y=%0d hs=%b vs=%b av=%b, want x=%0d y=%0d hs=%b vs=%b av=%b",
                 n, x_i, y_i, hs_i, vs_i, av_i,
                 want_i[22:13], want_i[12:3], want_i[2], want_i[1], want_i[0]);
      end
`ifdef VGA_FRAME_PULSE_EN
      tests_run++;
      if (fs_s !== ((n % (SHT * SVT)) == 0) || fs_i !== fs_s) begin
        tests_failed++;
        $display("FAIL frame_start n=%0d: got %b/%b, want %b", n, fs_s, fs_i,
                 ((n % (SHT * SVT)) == 0));
      end
      if (n < 2 * SHT * SVT && fs_s == 1'b1) fs_cnt++;
`endif
      if (n < SHT * SVT && vs_s == 1'b0) vs_lo++;
      if (n < SHT * SVT && vs_i == 1'b1) vs_hi++;
      tick();
    end
    tests_run++;
    if (vs_lo !== SVS * SHT || vs_hi !== SVS * SHT) begin
      tests_failed++;
      $display("FAIL vsync_width: got %0d/%0d clocks, want %0d", vs_lo, vs_hi, SVS * SHT);
    end
`ifdef VGA_FRAME_PULSE_EN
    tests_run++;
    if (fs_cnt !== 2) begin
      tests_failed++;
      $display("FAIL frame_start_count: got %0d, want 2", fs_cnt);
    end
`endif
  endtask

  task automatic test_mid_reset();
    int target;
    int run_len, hold;
    logic [22:0] want;
    rst_s = 1'b1;
    tick();
    rst_s  = 1'b0;
    // Position where both syncs are active: x=21, y=13.
    target = 13 * SHT + 21;
    for (int n = 0; n < target; n++) tick();
    tests_run++;
    if ({x_s, y_s, hs_s, vs_s, hs_i, vs_i} !== {10'd21, 10'd13, 1'b0, 1'b0, 1'b1, 1'b1}) begin
      tests_failed++;
      $display("FAIL pre_reset_pos: got x=%0d y=%0d hs=%b vs=%b inv hs=%b vs=%b, want 21 13 0 0 1 1",
               x_s, y_s, hs_s, vs_s, hs_i, vs_i);
    end
    for (int r = 0; r < 6; r++) begin
      rst_s = 1'b1;
      hold  = int'($urandom_range(1, 3));
      for (int h = 0; h < hold; h++) begin
        tick();
        tests_run++;
        if ({x_s, y_s, hs_s, vs_s, av_s, hs_i, vs_i, av_i} !==
            {10'd0, 10'd0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1}) begin
          tests_failed++;
          $display("FAIL mid_reset r=%0d: got x=%0d y=%0d hs=%b vs=%b av=%b inv hs=%b vs=%b av=%b",
                   r, x_s, y_s, hs_s, vs_s, av_s, hs_i, vs_i, av_i);
        end
      end
      rst_s   = 1'b0;
      run_len = int'($urandom_range(1, 700));
      for (int n = 0; n < run_len; n++) begin
        want = exp_vec(n, SHV, SHF, SHS, SHB, SVV, SVF, SVS, SVB, 1'b0);
        tests_run++;
        if ({x_s, y_s, hs_s, vs_s, av_s} !== want) begin
          tests_failed++;
          $display("FAIL after_reset r=%0d n=%0d: got x=%0d y=%0d hs=%b vs=%b av=%b, want x=%0d y=%0d",
                   r, n, x_s, y_s, hs_s, vs_s, av_s, want[22:13], want[12:3]);
        end
        tick();
      end
    end
  endtask

  initial begin
    test_reset();
    test_line();
    test_frame();
    test_mid_reset();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule

// File: doc/vga_sync_gen.md
VGA_SYNC_GEN -- requirements
Module: vga_sync_gen

Interface
REQ-001 SHALL have parameter H_VISIBLE, 640, active pixels per line.
REQ-002 SHALL have parameter H_FRONT, 24, horizontal front porch in pixels.
REQ-003 SHALL have parameter H_SYNC, 40, hsync pulse width in pixels.
REQ-004 SHALL have parameter H_BACK, 128, horizontal back porch in pixels.
REQ-005 SHALL have parameter V_VISIBLE, 480, active lines per frame.
REQ-006 SHALL have parameter V_FRONT, 9, vertical front porch in lines.
REQ-007 SHALL have parameter V_SYNC, 3, vsync pulse width in lines.
REQ-008 SHALL have parameter V_BACK, 28, vertical back porch in lines.
REQ-009 SHALL have parameter SYNC_ACTIVE, 0, asserted level of hsync and vsync.
REQ-010 SHALL have port px_clk, input, 1, pixel clock (31.5 MHz nominal); sole clock.
REQ-011 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-012 SHALL have port hsync, output, 1, horizontal sync.
REQ-013 SHALL have port vsync, output, 1, vertical sync.
REQ-014 SHALL have port x_px, output, 10, current pixel column.
REQ-015 SHALL have port y_px, output, 10, current line.
REQ-016 SHALL have port activevideo, output, 1, high while the pixel is in the visible area.
REQ-017 SHALL have port frame_start, output, 1, present only when VGA_FRAME_PULSE_EN is defined.

Function
REQ-018 SHALL define H_TOTAL = H_VISIBLE+H_FRONT+H_SYNC+H_BACK (default 832) and V_TOTAL = V_VISIBLE+V_FRONT+V_SYNC+V_BACK (default 520); both SHALL be at most 1024.
REQ-019 SHALL keep x_px and y_px in registers; x_px SHALL increment by 1 on every px_clk edge.
REQ-020 SHALL wrap x_px from H_TOTAL-1 to 0; y_px SHALL increment on that same edge and SHALL otherwise hold.
REQ-021 SHALL wrap y_px from V_TOTAL-1 to 0 when x_px wraps and y_px = V_TOTAL-1, i.e. at frame end.
REQ-022 SHALL set activevideo = (x_px < H_VISIBLE) AND (y_px < V_VISIBLE), decoded combinationally from the counter registers with zero latency.
REQ-023 SHALL drive hsync = SYNC_ACTIVE when x_px is in [H_VISIBLE+H_FRONT, H_VISIBLE+H_FRONT+H_SYNC), i.e. 664..703 by default, and = !SYNC_ACTIVE otherwise.
REQ-024 SHALL drive vsync = SYNC_ACTIVE when y_px is in [V_VISIBLE+V_FRONT, V_VISIBLE+V_FRONT+V_SYNC), i.e. 489..491 by default, and = !SYNC_ACTIVE otherwise; vsync SHALL depend on y_px only, not on x_px.
REQ-025 SHALL produce a frame period of H_TOTAL*V_TOTAL = 432,640 clocks by default (about 72.8 Hz at 31.5 MHz).
REQ-026 SHALL never let x_px reach H_TOTAL or y_px reach V_TOTAL, including on the cycle after reset.

Reset
REQ-027 SHALL, while reset is high at a px_clk edge, load x_px=0 and y_px=0; reset SHALL take priority over counting.
REQ-028 SHALL, during and immediately after reset, present activevideo=1, hsync=!SYNC_ACTIVE, vsync=!SYNC_ACTIVE, and frame_start=1 when that port is present.
REQ-029 SHALL, when reset is asserted mid-line or mid-frame, restart at (0,0) on the next edge, with no partial sync pulse carried over.
REQ-030 SHALL resume counting on the first edge after reset deasserts (x_px=1).

Configuration
REQ-031 SHALL, when macro VGA_FRAME_PULSE_EN is defined, provide frame_start = (x_px==0 AND y_px==0), decoded combinationally: a one-clock pulse once per frame, usable as a button-debounce clock enable.
REQ-032 SHALL, when VGA_FRAME_PULSE_EN is undefined, omit the frame_start port and its logic, with all other behaviour identical.

Verification
REQ-033 SHALL cover: reset held 3 clocks then released -> x_px=0, y_px=0, hsync=1, vsync=1, activevideo=1; one clock later x_px=1.
REQ-034 SHALL cover: run one line -> activevideo falls at x_px=640; hsync low exactly for x_px 664..703 (40 clocks); x_px wraps 831->0 while y_px goes 0->1.
REQ-035 SHALL cover: run one full frame -> vsync low for lines 489..491 (3*832 = 2496 clocks); y_px wraps 519->0 after exactly 432,640 clocks.
REQ-036 SHALL cover: assert reset at x_px=700, y_px=490, while both syncs are active -> next edge shows x_px=0, y_px=0, hsync=1, vsync=1.
REQ-037 SHALL cover: with VGA_FRAME_PULSE_EN defined, run 2 frames -> frame_start high for exactly 1 clock per 432,640 clocks, always at (0,0).
REQ-038 SHALL cover: SYNC_ACTIVE=1 -> hsync and vsync waveforms are the inverse of the default, with timing unchanged.
